// File: rtl/sof_frame_scheduler.sv
// Host SOF / keep-alive scheduler: arbitrates for the send-packet path before each frame
// boundary, writes the SOF at frame end, and tracks frame numbers and missed frames.
module sof_frame_scheduler #(
    parameter int unsigned               TIMER_W      = 16,
    parameter logic [TIMER_W-1:0]        FRAME_END    = 16'hBB79,
    parameter logic [TIMER_W-1:0]        FS_MARGIN    = 16'h0C80,
    parameter logic [TIMER_W-1:0]        LS_MARGIN    = 16'h6400,
    parameter int unsigned               GUARD_CYCLES = 256,
    parameter int unsigned               FRAME_NUM_W  = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   SOFEnable,
    input  logic                   SOFSyncEn,
    input  logic                   fullSpeedRate,
    input  logic [TIMER_W-1:0]     SOFTimer,
    input  logic                   sendPacketArbiterGnt,
    input  logic                   sendPacketRdy,
    output logic                   sendPacketArbiterReq,
    output logic                   sendPacketWEn,
    output logic                   SOFTimerClr,
    output logic                   SOFSent,
    output logic                   keepAlive,
    output logic [FRAME_NUM_W-1:0] frameNum,
    output logic                   frameOverrun
);

    localparam int unsigned GuardW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GuardW-1:0] GuardLast = GuardW'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        StInit,
        StWaitNear,
        StReq,
        StWaitEnd,
        StTx,
        StGuard1,
        StGuard2
    } state_e;

    state_e                 state_q, state_d;
    logic                   req_q, req_d;
    logic                   wen_q, wen_d;
    logic                   clr_q, clr_d;
    logic                   sent_q, sent_d;
    logic                   keep_alive_q, keep_alive_d;
    logic                   overrun_q, overrun_d;
    logic                   wrote_q, wrote_d;
    logic [FRAME_NUM_W-1:0] frame_num_q, frame_num_d;
    logic [TIMER_W-1:0]     near_time_q, near_time_d;
    logic [GuardW-1:0]      guard_cnt_q, guard_cnt_d;

    logic at_near;
    logic at_end;

    assign at_near = (SOFTimer >= near_time_q);
    assign at_end  = (SOFTimer >= FRAME_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StInit;
            req_q        <= 1'b0;
            wen_q        <= 1'b0;
            clr_q        <= 1'b0;
            sent_q       <= 1'b0;
            keep_alive_q <= 1'b0;
            overrun_q    <= 1'b0;
            wrote_q      <= 1'b0;
            frame_num_q  <= '0;
            near_time_q  <= '0;
            guard_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            wen_q        <= wen_d;
            clr_q        <= clr_d;
            sent_q       <= sent_d;
            keep_alive_q <= keep_alive_d;
            overrun_q    <= overrun_d;
            wrote_q      <= wrote_d;
            frame_num_q  <= frame_num_d;
            near_time_q  <= near_time_d;
            guard_cnt_q  <= guard_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        wen_d        = 1'b0;
        clr_d        = 1'b0;
        sent_d       = 1'b0;
        overrun_d    = 1'b0;
        keep_alive_d = keep_alive_q;
        wrote_d      = wrote_q;
        frame_num_d  = frame_num_q;
        guard_cnt_d  = guard_cnt_q;
        near_time_d  = FRAME_END - (fullSpeedRate ? FS_MARGIN : LS_MARGIN);

        unique case (state_q)
            StInit: begin
                // One idle cycle lets near_time settle after reset.
                state_d = StWaitNear;
            end
            StWaitNear: begin
                if (at_near || (SOFSyncEn && SOFEnable)) begin
                    req_d   = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                // Grant takes priority over a boundary passing in the same cycle.
                if (sendPacketArbiterGnt && sendPacketRdy) begin
                    state_d = StWaitEnd;
                end else if (at_end) begin
                    overrun_d   = 1'b1;
                    clr_d       = 1'b1;
                    frame_num_d = frame_num_q + 1'b1;
                end
            end
            StWaitEnd: begin
                if (at_end) begin
                    wen_d        = 1'b1;
                    clr_d        = 1'b1;
                    sent_d       = 1'b1;
                    keep_alive_d = ~fullSpeedRate;
                    wrote_d      = 1'b1;
                    state_d      = StTx;
                end else if (!SOFEnable) begin
                    clr_d   = 1'b1;
                    wrote_d = 1'b0;
                    state_d = StTx;
                end
            end
            StTx: begin
                // frameNum must stay stable while WEn is high, so advance it here.
                if (wrote_q) begin
                    frame_num_d = frame_num_q + 1'b1;
                end
                wrote_d = 1'b0;
                if (sendPacketRdy) begin
                    guard_cnt_d = '0;
                    state_d     = StGuard1;
                end
            end
            StGuard1: begin
                if (guard_cnt_q == GuardLast) begin
                    req_d       = 1'b0;
                    guard_cnt_d = '0;
                    state_d     = StGuard2;
                end else begin
                    guard_cnt_d = guard_cnt_q + 1'b1;
                end
            end
            StGuard2: begin
                if (guard_cnt_q == GuardLast) begin
                    guard_cnt_d = '0;
                    state_d     = StWaitNear;
                end else begin
                    guard_cnt_d = guard_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    assign sendPacketArbiterReq = req_q;
    assign sendPacketWEn        = wen_q;
    assign SOFTimerClr          = clr_q;
    assign SOFSent              = sent_q;
    assign keepAlive            = keep_alive_q;
    assign frameNum             = frame_num_q;
    assign frameOverrun         = overrun_q;

endmodule
